// File: rtl/modmul163841_arb2.sv
// modmul163841_arb2: two requesters share one pipelined signed multiplier whose products are
// reduced to the centered residue mod 163841 and returned through per-requester FWFT FIFOs.
module modmul163841_arb2 #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [17:0] req0_a,
    input  logic signed [17:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [17:0] req1_a,
    input  logic signed [17:0] req1_b,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic signed [17:0] out0_data,
    output logic               out1_valid,
    input  logic               out1_ready,
    output logic signed [17:0] out1_data,
    output logic               busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic signed [20:0] M = 21'sd163841;
    localparam logic signed [20:0] HALF = 21'sd81920;
    localparam logic signed [59:0] K = 60'((64'd1 << 40) / 64'd163841);

    logic               rst_q, last, live;
    logic [1:0]         el, rdy, wr, pop, ov;
    logic [3:0]         sv, st;
    logic [CW-1:0]      used [2];
    logic [CW-1:0]      fcnt [2];
    logic [PW-1:0]      wptr [2];
    logic [PW-1:0]      rptr [2];
    logic signed [17:0] mem [2][DEPTH];
    logic signed [17:0] op_a, op_b, res;
    logic signed [34:0] prod, rp;
    logic signed [19:0] q;
    logic signed [20:0] rem, c1;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // used[] counts issued-but-not-popped ops, i.e. in-flight plus FIFO occupancy
    always_comb begin
        live = !rst && !rst_q;
        el[0] = req0_valid && used[0] < CW'(DEPTH);
        el[1] = req1_valid && used[1] < CW'(DEPTH);
        rdy[0] = live && el[0] && (!el[1] || last);
        rdy[1] = live && el[1] && (!el[0] || !last);
        ov[0] = !rst && fcnt[0] != '0;
        ov[1] = !rst && fcnt[1] != '0;
        pop = ov & {out1_ready, out0_ready};
        wr = {sv[3] & st[3], sv[3] & ~st[3]};
        c1 = rem > HALF ? rem - M : rem < -HALF ? rem + M : rem;
        res = 18'(c1 > HALF ? c1 - M : c1 < -HALF ? c1 + M : c1);
    end

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign out0_valid = ov[0];
    assign out1_valid = ov[1];
    assign out0_data = mem[0][rptr[0]];
    assign out1_data = mem[1][rptr[1]];
    assign busy = !rst && (used[0] != '0 || used[1] != '0);

    // Barrett quotient estimate is within one of floor(p/M), so the remainder lands in [-M, 2M)
    always_ff @(posedge clk) begin
        op_a <= rdy[1] ? req1_a : req0_a;
        op_b <= rdy[1] ? req1_b : req0_b;
        st <= {st[2:0], rdy[1]};
        prod <= 35'(op_a) * 35'(op_b);
        rp <= prod;
        q <= 20'((60'(prod) * K) >>> 40);
        rem <= 21'(rp - 35'(q) * 35'(M));
        for (int i = 0; i < 2; i++)
            if (wr[i]) mem[i][wptr[i]] <= res;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            sv <= '0;
            last <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                used[i] <= '0;
                fcnt[i] <= '0;
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            sv <= {sv[2:0], |rdy};
            if (|rdy) last <= rdy[1];
            for (int i = 0; i < 2; i++) begin
                used[i] <= used[i] + CW'(rdy[i]) - CW'(pop[i]);
                fcnt[i] <= fcnt[i] + CW'(wr[i]) - CW'(pop[i]);
                if (wr[i]) wptr[i] <= nxt(wptr[i]);
                if (pop[i]) rptr[i] <= nxt(rptr[i]);
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst)
            assert (!(wr[0] && !pop[0] && fcnt[0] == CW'(DEPTH)) &&
                    !(wr[1] && !pop[1] && fcnt[1] == CW'(DEPTH)));
endmodule

// File: tb/tb_modmul163841_arb2.sv
// tb_modmul163841_arb2: directed vectors, arbitration/credit model and per-requester scoreboard.
module tb_modmul163841_arb2;
    localparam int DEPTH = 4;
    localparam longint MOD = 163841;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0, or0 = 1'b1, or1 = 1'b1;
    logic r0, r1, o0v, o1v, busy;
    logic signed [17:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, o0d, o1d;

    modmul163841_arb2 #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
        .out0_valid(o0v), .out0_ready(or0), .out0_data(o0d),
        .out1_valid(o1v), .out1_ready(or1), .out1_data(o1d),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     n;
        longint a, b, exp;
    } vec_t;

    int total = 0, bad = 0;
    int used0 = 0, used1 = 0;
    bit last = 1'b1, prst = 1'b1;
    bit hold0 = 1'b0, hold1 = 1'b0, dr0, dr1;
    longint hd0, hd1;
    longint q0[$], q1[$];
    vec_t vt[10];

    function automatic longint model(input longint a, input longint b);
        longint r = (a * b) % MOD;
        if (r > 81920) r -= MOD;
        else if (r < -81920) r += MOD;
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock cycle: inputs already driven at the negedge, compare mid-cycle, then advance
    task automatic tick();
        bit live, e0, e1, g0, g1, p0, p1;
        longint x;
        #1;
        live = !rst && !prst;
        e0 = v0 && used0 < DEPTH;
        e1 = v1 && used1 < DEPTH;
        g0 = live && e0 && (!e1 || last);
        g1 = live && e1 && (!e0 || !last);
        dr0 = r0;
        dr1 = r1;
        check("rdy0", r0, g0);
        check("rdy1", r1, g1);
        check("busy", busy, !rst && (used0 + used1) > 0);
        if (rst) check("rst_out_valid", o0v | o1v, 0);
        if (hold0 && !rst) begin
            check("hold_v0", o0v, 1);
            check("hold_d0", o0d, hd0);
        end
        if (hold1 && !rst) begin
            check("hold_v1", o1v, 1);
            check("hold_d1", o1d, hd1);
        end
        p0 = o0v && or0;
        p1 = o1v && or1;
        if (p0) begin
            check("expected0", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                x = q0.pop_front();
                check("data0", o0d, x);
            end
        end
        if (p1) begin
            check("expected1", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                x = q1.pop_front();
                check("data1", o1d, x);
            end
        end
        if (g0) q0.push_back(model(longint'(a0), longint'(b0)));
        if (g1) q1.push_back(model(longint'(a1), longint'(b1)));
        if (rst) begin
            q0.delete();
            q1.delete();
            used0 = 0;
            used1 = 0;
            last = 1'b1;
            hold0 = 1'b0;
            hold1 = 1'b0;
        end else begin
            used0 += int'(g0) - int'(p0);
            used1 += int'(g1) - int'(p1);
            if (g0 || g1) last = g1;
            hold0 = o0v && !or0;
            hold1 = o1v && !or1;
            hd0 = longint'(o0d);
            hd1 = longint'(o1d);
        end
        prst = rst;
        @(negedge clk);
    endtask

    task automatic rnd_ops();
        a0 = 18'(int'($urandom_range(0, 163840)) - 81920);
        b0 = 18'(int'($urandom_range(0, 163840)) - 81920);
        a1 = 18'(int'($urandom_range(0, 163840)) - 81920);
        b1 = 18'(int'($urandom_range(0, 163840)) - 81920);
    endtask

    initial begin
        int lat, h0;
        vt[0] = '{0, 2, 3, 6};
        vt[1] = '{1, 81920, 81920, -40960};
        vt[2] = '{0, -5, 7, -35};
        vt[3] = '{1, -81920, 81920, 40960};
        vt[4] = '{0, 0, 0, 0};
        vt[5] = '{1, 81920, 2, -1};
        vt[6] = '{0, 1, -1, -1};
        vt[7] = '{1, 40000, 40000, -71206};
        vt[8] = '{0, 12345, -6789, 76387};
        vt[9] = '{1, -81920, 1, -81920};

        // reset: requests pending, nothing may be accepted during reset or the cycle after
        v0 = 1'b1;
        v1 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("post_rst_rdy", r0 | r1, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", o0v | o1v, 0);
        tick();
        v0 = 1'b0;
        v1 = 1'b0;

        // single operations: value, fixed latency, busy drops after consumption
        for (int k = 0; k < 10; k++) begin
            if (vt[k].n) begin
                v1 = 1'b1; a1 = 18'(vt[k].a); b1 = 18'(vt[k].b);
            end else begin
                v0 = 1'b1; a0 = 18'(vt[k].a); b0 = 18'(vt[k].b);
            end
            tick();
            v0 = 1'b0;
            v1 = 1'b0;
            lat = 0;
            while (!(vt[k].n ? o1v : o0v) && lat < 10) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_lat", k), lat, 4);
            check($sformatf("vec%0d_data", k), vt[k].n ? longint'(o1d) : longint'(o0d), vt[k].exp);
            tick();
            check($sformatf("vec%0d_idle", k), busy, 0);
        end

        // round robin from reset: 0,1,0,1...
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        v0 = 1'b1;
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rnd_ops();
            tick();
            check("alt0", dr0, i % 2 == 0);
            check("alt1", dr1, i % 2 == 1);
        end
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (12) tick();

        // backpressure on requester 0: credits cap it at DEPTH while requester 1 continues
        or0 = 1'b0;
        v0 = 1'b1;
        v1 = 1'b1;
        h0 = 0;
        for (int i = 0; i < 16; i++) begin
            rnd_ops();
            tick();
            h0 += int'(dr0);
        end
        check("bp_issues0", h0, DEPTH);
        v0 = 1'b0;
        v1 = 1'b0;
        or0 = 1'b1;
        repeat (20) tick();

        // reset with three ops in flight and one result queued
        or0 = 1'b0;
        v0 = 1'b1;
        repeat (4) begin
            rnd_ops();
            tick();
        end
        v0 = 1'b0;
        tick();
        check("queued_before_rst", o0v, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        or0 = 1'b1;
        #1;
        check("mid_rst_valid", o0v | o1v, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rdy", r0 | r1, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_stale", o0v | o1v, 0);
        end

        // random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            rnd_ops();
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            or0 = $urandom_range(0, 3) != 0;
            or1 = $urandom_range(0, 3) != 0;
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        or0 = 1'b1;
        or1 = 1'b1;
        repeat (25) tick();
        check("left0", q0.size(), 0);
        check("left1", q1.size(), 0);
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modmul163841_arb2.md
MODMUL163841_ARB2 -- requirements
Module: modmul163841_arb2

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the per-requester result FIFO depth and the credit limit.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1, operand pair offered by requester 0/1.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1, operand pair accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 18 signed, operands in [-81920, 81920].
REQ-007 SHALL have ports out0_valid/out1_valid, output, 1, result available for requester 0/1.
REQ-008 SHALL have ports out0_ready/out1_ready, input, 1, requester consumes result.
REQ-009 SHALL have ports out0_data/out1_data, output, 18 signed, result in [-81920, 81920].
REQ-010 SHALL have port busy, output, 1, set while any operation is in flight or any FIFO holds data.

Function
REQ-011 SHALL treat a handshake as reqN_valid && reqN_ready high at a rising edge.
REQ-012 SHALL assert at most one of req0_ready/req1_ready per cycle, since there is a single shared datapath.
REQ-013 SHALL drive reqN_ready combinationally from reqN_valid, credit availability for N, and the arbitration outcome; it SHALL NOT depend on out*_ready within the same cycle.
REQ-014 SHALL use round-robin arbitration: when both requesters are eligible, grant the one not granted last; when only one is eligible, grant it; the last-grant pointer SHALL update only on a handshake.
REQ-015 SHALL treat requester N as eligible when reqN_valid=1 and (FIFO_N occupancy + in-flight ops tagged N) < DEPTH.
REQ-016 SHALL register the 35-bit signed product a*b with a tag (0/1) one edge after the handshake.
REQ-017 SHALL pass the product and tag through a 3-stage signed reduction mod 163841, so the tag and valid bit shift alongside the data.
REQ-018 SHALL write the result to FIFO_N on the 4th rising edge after the handshake edge, giving a fixed issue-to-FIFO latency of 4.
REQ-019 SHALL produce a result congruent to a*b mod 163841 that lies in [-81920, 81920]; for operands outside the input range, the data is unspecified but control behaviour is unaffected.
REQ-020 SHALL make FIFO_N first-word-fall-through: with FIFO_N empty and outN_ready=1, outN_valid rises in the cycle after the write edge.
REQ-021 SHALL deliver results per requester in handshake order; FIFO_0 and FIFO_1 are independent.
REQ-022 SHALL allow a simultaneous write and read of the same FIFO in one cycle, with occupancy unchanged.
REQ-023 SHALL never overflow a FIFO; the credit check guarantees this, and overflow is an assertion failure in verification.
REQ-024 SHALL hold outN_data and outN_valid stable while outN_valid=1 and outN_ready=0.
REQ-025 SHALL sustain one issue per cycle when credits are available, independent of requester.

Reset
REQ-026 SHALL, while rst=1 at an edge, clear all pipeline valid bits, FIFO pointers, occupancy and in-flight counters, and set the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-027 SHALL hold out0_valid, out1_valid, req0_ready, req1_ready and busy at 0 during reset and in the first cycle after reset.
REQ-028 SHALL drop operations in flight when rst is asserted mid-operation; no stale result SHALL appear after reset deasserts.
REQ-029 SHALL not require any data-path register to be reset; only control state needs reset.

Verification
REQ-030 SHALL cover: req0 a=2, b=3, out0_ready=1 -> out0_valid=1, out0_data=6 in the cycle after the 4th edge post-handshake; busy falls afterwards.
REQ-031 SHALL cover: req1 a=81920, b=81920 -> out1_data=-40960; req0 a=-5, b=7 -> out0_data=-35.
REQ-032 SHALL cover: both valid every cycle, both outN_ready=1 -> grants alternate 0,1,0,1 starting with 0, and results return in the same interleave.
REQ-033 SHALL cover: out0_ready=0 with req0_valid held -> exactly 4 req0 handshakes, then req0_ready=0 while req1 keeps issuing every cycle; raising out0_ready drains 4 results in order.
REQ-034 SHALL cover: rst pulsed for 1 cycle with 3 ops in flight and 1 result queued -> all valids=0 and busy=0 next cycle, and no result appears within 8 cycles.
REQ-035 SHALL cover: random operands in [-81920, 81920] with random ready/valid -> every result matches a reference model of the centered residue, with no loss, duplication or reordering.
